regfile_mp: RTL

Parametrised multi-port register file, the next-generation general-purpose register array for the CPU datapath. It has one write port and two read ports, configurable data width and depth, and an optional hard-wired zero register. Reads are registered on the rising edge with write-first bypass. A sequenced clear engine zeroes the array on request while flagging any writes it drops.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_seq.sv | 69 ++++++
 rtl/regfile_mp.sv | 112 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// clear-sequencer state encoding and depth derivation.
package regfile_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int depth_of(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: on request, sweeps every register address once, one per
// cycle, and closes the port write path while the sweep is running.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_sweep_we,
    output logic [ADDR_W-1:0] o_sweep_addr,
    output logic              o_port_wr_en
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    // State and sweep counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; requests arriving mid-sweep are ignored
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign o_busy       = (r_state == ST_CLEAR);
    assign o_sweep_we   = (r_state == ST_CLEAR);
    assign o_sweep_addr = r_cnt;
    assign o_port_wr_en = (r_state == ST_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// One-write / two-read register file with registered write-first reads,
// optional hard-wired zero register and a sequenced array clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr1,
    input  logic [ADDR_W-1:0] r_addr2,
    output logic [DATA_W-1:0] r_data1,
    output logic [DATA_W-1:0] r_data2,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_sweep_we;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_port_wr_en;
    logic              w_zero_hit;
    logic              w_eff_we;
    logic [ADDR_W-1:0] w_eff_addr;
    logic [DATA_W-1:0] w_eff_data;
    logic [DATA_W-1:0] w_rd1_nxt;
    logic [DATA_W-1:0] w_rd2_nxt;
    logic              w_drop_nxt;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_req    (clr_req),
        .o_busy       (busy),
        .o_sweep_we   (w_sweep_we),
        .o_sweep_addr (w_sweep_addr),
        .o_port_wr_en (w_port_wr_en)
    );

    // Select the single write applied this edge: the sweep has priority
    always_comb begin
        w_zero_hit = ZERO_REG && (w_addr == {ADDR_W{1'b0}});
        w_drop_nxt = we && !w_port_wr_en;
        if (w_sweep_we) begin
            w_eff_we   = 1'b1;
            w_eff_addr = w_sweep_addr;
            w_eff_data = {DATA_W{1'b0}};
        end else if (w_port_wr_en && we && !w_zero_hit) begin
            w_eff_we   = 1'b1;
            w_eff_addr = w_addr;
            w_eff_data = w_data;
        end else begin
            w_eff_we   = 1'b0;
            w_eff_addr = w_addr;
            w_eff_data = w_data;
        end
    end

    // Read muxes: zero register, then same-edge write bypass, then array
    always_comb begin
        if (ZERO_REG && (r_addr1 == {ADDR_W{1'b0}})) begin
            w_rd1_nxt = {DATA_W{1'b0}};
        end else if (w_eff_we && (w_eff_addr == r_addr1)) begin
            w_rd1_nxt = w_eff_data;
        end else begin
            w_rd1_nxt = r_mem[r_addr1];
        end
        if (ZERO_REG && (r_addr2 == {ADDR_W{1'b0}})) begin
            w_rd2_nxt = {DATA_W{1'b0}};
        end else if (w_eff_we && (w_eff_addr == r_addr2)) begin
            w_rd2_nxt = w_eff_data;
        end else begin
            w_rd2_nxt = r_mem[r_addr2];
        end
    end

    // Register array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (w_eff_we) begin
            r_mem[w_eff_addr] <= w_eff_data;
        end
    end

    // Registered read data and dropped-write pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data1 <= {DATA_W{1'b0}};
            r_data2 <= {DATA_W{1'b0}};
            wr_drop <= 1'b0;
        end else begin
            r_data1 <= w_rd1_nxt;
            r_data2 <= w_rd2_nxt;
            wr_drop <= w_drop_nxt;
        end
    end

endmodule
